// File: rtl/essr_bank_if.sv
// Bus bundle for essr_bank: per-channel set/clear requests in, channel state and
// transition statistics out.
interface essr_bank_if #(
    parameter int N     = 5,
    parameter int CNT_W = 8
);
    logic             en;
    logic [N-1:0]     x;
    logic [N-1:0]     z;
    logic             clr_cnt;
    logic [N-1:0]     g;
    logic [N-1:0]     gn;
    logic [N-1:0]     chg;
    logic [CNT_W-1:0] cnt;

    modport master (
        output en, x, z, clr_cnt,
        input  g, gn, chg, cnt
    );

    modport slave (
        input  en, x, z, clr_cnt,
        output g, gn, chg, cnt
    );
endinterface

// File: rtl/essr_bank.sv
// Bank of N set/clear storage channels with optional per-input debounce, selectable
// set/clear conflict rule and a shared saturating transition counter.

// Debounce filter for an N-bit input vector. Output moves to 1 after FILT consecutive
// sampled 1s, to 0 after FILT consecutive sampled 0s, and holds otherwise.
module essr_bank_filt #(
    parameter int N    = 5,
    parameter int FILT = 2
) (
    input  logic         clk,
    input  logic         r,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    logic [N-1:0] hist [FILT];
    logic [N-1:0] held;
    logic [N-1:0] all_one;
    logic [N-1:0] all_zero;

    // NOTE: every variable gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        all_one  = '1;
        all_zero = '1;
        for (int i = 0; i < FILT; i++) begin
            all_one  = all_one & hist[i];
            all_zero = all_zero & ~hist[i];
        end
    end

    // A fresh run of FILT equal samples wins; otherwise the previous decision persists.
    assign q = (held | all_one) & ~all_zero;

    always_ff @(posedge clk) begin
        if (r) begin
            // NOTE: the history is reset along with the rest of the state so a reset
            // mid-debounce cannot leave stale samples that would count toward a run.
            for (int i = 0; i < FILT; i++) begin
                hist[i] <= '0;
            end
            held <= '0;
        end else begin
            hist[0] <= d;
            for (int i = 1; i < FILT; i++) begin
                hist[i] <= hist[i-1];
            end
            held <= q;
        end
    end
endmodule

module essr_bank #(
    parameter int           N     = 5,
    parameter int           MODE  = 0,
    parameter logic [N-1:0] INIT  = '0,
    parameter int           FILT  = 2,
    parameter int           CNT_W = 8
) (
    input  logic        clk,
    input  logic        r,
    essr_bank_if.slave  bus
);
    localparam int MODE_CLEAR  = 0;
    localparam int MODE_SET    = 1;
    localparam int MODE_TOGGLE = 2;

    logic [N-1:0]     x_f;
    logic [N-1:0]     z_f;
    logic [N-1:0]     g_q;
    logic [N-1:0]     gn_q;
    logic [N-1:0]     chg_q;
    logic [CNT_W-1:0] cnt_q;

    logic [N-1:0]       g_next;
    logic [N-1:0]       diff;
    logic [5:0]         pop;
    logic [CNT_W+5:0]   sum;
    logic [CNT_W-1:0]   cnt_next;

    if (FILT == 0) begin : g_bypass
        assign x_f = bus.x;
        assign z_f = bus.z;
    end else begin : g_filter
        essr_bank_filt #(.N(N), .FILT(FILT)) u_filt_x (
            .clk (clk),
            .r   (r),
            .d   (bus.x),
            .q   (x_f)
        );
        essr_bank_filt #(.N(N), .FILT(FILT)) u_filt_z (
            .clk (clk),
            .r   (r),
            .d   (bus.z),
            .q   (z_f)
        );
    end

    always_comb begin
        g_next = g_q;
        if (bus.en) begin
            for (int i = 0; i < N; i++) begin
                unique case ({x_f[i], z_f[i]})
                    2'b10:   g_next[i] = 1'b1;
                    2'b01:   g_next[i] = 1'b0;
                    2'b11: begin
                        case (MODE)
                            MODE_CLEAR:  g_next[i] = 1'b0;
                            MODE_SET:    g_next[i] = 1'b1;
                            MODE_TOGGLE: g_next[i] = ~g_q[i];
                            default:     g_next[i] = g_q[i];
                        endcase
                    end
                    default: g_next[i] = g_q[i];
                endcase
            end
        end
    end

    // The sum carries six guard bits so a full-bank change can never wrap before clipping.
    always_comb begin
        diff     = g_next ^ g_q;
        pop      = 6'($countones(diff));
        sum      = {6'b0, cnt_q} + {{CNT_W{1'b0}}, pop};
        cnt_next = (|sum[CNT_W+5:CNT_W]) ? '1 : sum[CNT_W-1:0];
    end

    // NOTE: state registers use non-blocking assignment so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (r) begin
            g_q   <= INIT;
            gn_q  <= ~INIT;
            chg_q <= '0;
            cnt_q <= '0;
        end else begin
            g_q   <= g_next;
            gn_q  <= ~g_next;
            chg_q <= diff;
            cnt_q <= bus.clr_cnt ? '0 : cnt_next;
        end
    end

    assign bus.g   = g_q;
    assign bus.gn  = gn_q;
    assign bus.chg = chg_q;
    assign bus.cnt = cnt_q;
endmodule
